// File: rtl/matcher_pkg.sv
// Shared types for the matcher engine and its scheduler.
package matcher_pkg;

  // Scheduler FSM states; the engine reuses this typedef for its own state view.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } sched_state_t;

  // Index increment that wraps n-1 back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/match_scheduler_if.sv
// Requester/consumer side bundle of the match scheduler.
//
// Handshakes: a transfer happens in a cycle where both valid and ready are
// high. The requester holds req_valid[i] and its address slice until it sees
// req_ready[i]; the scheduler holds rsp_valid and every rsp_* field stable
// until it sees rsp_ready. Neither ready depends on the same-side valid being
// withdrawn, and valid is never retracted before its transfer.
interface match_scheduler_if #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int ID_W       = $clog2(N_REQ)
) ();
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*ADDR_WIDTH-1:0] req_input_addr;
  logic [N_REQ-1:0]            req_ready;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [ID_W-1:0]             rsp_id;
  logic                        rsp_found;
  logic                        rsp_timeout;
  logic [ADDR_WIDTH-1:0]       rsp_vocab_addr;

  // Requesters and response consumer.
  modport master (
    output req_valid, req_input_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_found, rsp_timeout, rsp_vocab_addr
  );

  // The scheduler.
  modport slave (
    input  req_valid, req_input_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_found, rsp_timeout, rsp_vocab_addr
  );
endinterface

// File: rtl/match_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr.
module rr_arbiter
  import matcher_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             any
);

  int idx;

  // Walk ptr, ptr+1, ... (mod N_REQ) and keep the first requester found.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = int'(ptr);
    for (int k = 0; k < N_REQ; k++) begin
      if (!any && req[ID_W'(idx)]) begin
        any              = 1'b1;
        gnt[ID_W'(idx)]  = 1'b1;
        gnt_idx          = ID_W'(idx);
      end
      idx = wrap_inc(idx, N_REQ);
    end
  end

endmodule

// File: rtl/match_scheduler.sv
// Shares one vocabulary-matcher engine among N_REQ requesters: round-robin
// accept, clear + launch the engine, wait with a watchdog, return the result.
module match_scheduler
  import matcher_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int ADDR_WIDTH = 4,
  parameter  int TIMEOUT    = 255,
  localparam int ID_W       = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  match_scheduler_if.slave      bus,
  input  logic [ADDR_WIDTH-1:0] vocab_start_addr,
  input  logic [ADDR_WIDTH-1:0] vocab_end_addr,
  output logic                  eng_clr,
  output logic                  eng_cs,
  output logic [ADDR_WIDTH-1:0] eng_vocab_start_addr,
  output logic [ADDR_WIDTH-1:0] eng_vocab_end_addr,
  output logic [ADDR_WIDTH-1:0] eng_input_start_addr,
  input  logic                  eng_done,
  input  logic                  eng_found,
  input  logic [ADDR_WIDTH-1:0] eng_addr_v,
  output sched_state_t          dbg_state
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  sched_state_t          state, state_next;
  logic [N_REQ-1:0]      gnt;
  logic [ID_W-1:0]       gnt_idx;
  logic                  any;
  logic [ID_W-1:0]       ptr;
  logic [ID_W-1:0]       g_q;
  logic [WD_W-1:0]       wd;
  logic                  wd_expired;
  logic [ADDR_WIDTH-1:0] in_addr_q, vs_q, ve_q, vaddr_q;
  logic                  found_q, timeout_q;
  logic [N_REQ-1:0]      req_ready_c;
  logic                  eng_clr_c, eng_cs_c;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign wd_expired = (wd == WD_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state and strobe outputs; reset forces the engine cleared and idles the strobes.
  always_comb begin
    state_next  = state;
    req_ready_c = '0;
    eng_clr_c   = rst;
    eng_cs_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (any) begin
          req_ready_c = gnt;
          state_next  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        eng_clr_c  = 1'b1;
        state_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        eng_cs_c   = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done || wd_expired) state_next = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (rst) begin
      req_ready_c = '0;
      eng_cs_c    = 1'b0;
    end
  end

  // Job latches, watchdog, result capture and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      g_q       <= '0;
      wd        <= '0;
      in_addr_q <= '0;
      vs_q      <= '0;
      ve_q      <= '0;
      vaddr_q   <= '0;
      found_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any) begin
            g_q       <= gnt_idx;
            in_addr_q <= bus.req_input_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            vs_q      <= vocab_start_addr;
            ve_q      <= vocab_end_addr;
          end
        end
        S_LAUNCH: wd <= '0;
        S_WAIT: begin
          // A done arriving in the expiry cycle still counts as a real result.
          if (eng_done) begin
            found_q   <= eng_found;
            vaddr_q   <= eng_addr_v;
            timeout_q <= 1'b0;
          end else if (wd_expired) begin
            found_q   <= 1'b0;
            vaddr_q   <= '0;
            timeout_q <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) ptr <= ID_W'(wrap_inc(int'(g_q), N_REQ));
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready          = req_ready_c;
  assign bus.rsp_valid          = (state == S_RESP) && !rst;
  assign bus.rsp_id             = g_q;
  assign bus.rsp_found          = found_q;
  assign bus.rsp_timeout        = timeout_q;
  assign bus.rsp_vocab_addr     = vaddr_q;
  assign eng_clr                = eng_clr_c;
  assign eng_cs                 = eng_cs_c;
  assign eng_vocab_start_addr   = vs_q;
  assign eng_vocab_end_addr     = ve_q;
  assign eng_input_start_addr   = in_addr_q;
  assign dbg_state              = state;

endmodule

// File: tb/tb_match_scheduler.sv
// Bench for match_scheduler: directed scenarios plus randomized jobs, with the
// bench acting as the matcher engine and a scoreboard of expected responses.
module tb_match_scheduler;
  import matcher_pkg::*;

  localparam int N_REQ   = 4;
  localparam int AW      = 4;
  localparam int TIMEOUT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  match_scheduler_if #(.N_REQ(N_REQ), .ADDR_WIDTH(AW)) bus ();

  logic [AW-1:0] vocab_start_addr, vocab_end_addr;
  logic [AW-1:0] eng_vocab_start_addr, eng_vocab_end_addr, eng_input_start_addr;
  logic [AW-1:0] eng_addr_v;
  logic          eng_clr, eng_cs, eng_done, eng_found;
  sched_state_t  dbg_state;

  match_scheduler #(.N_REQ(N_REQ), .ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .bus                  (bus),
    .vocab_start_addr     (vocab_start_addr),
    .vocab_end_addr       (vocab_end_addr),
    .eng_clr              (eng_clr),
    .eng_cs               (eng_cs),
    .eng_vocab_start_addr (eng_vocab_start_addr),
    .eng_vocab_end_addr   (eng_vocab_end_addr),
    .eng_input_start_addr (eng_input_start_addr),
    .eng_done             (eng_done),
    .eng_found            (eng_found),
    .eng_addr_v           (eng_addr_v),
    .dbg_state            (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];   // {id[1:0], found, timeout, vocab_addr[3:0]}
  int         model_ptr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference arbitration: lowest distance from the pointer, counting upward with wrap.
  function automatic int model_grant(input logic [3:0] v, input int p);
    for (int k = 0; k < N_REQ; k++) begin
      int i;
      i = (p + k) % N_REQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] rsp_now();
    return {bus.rsp_id, bus.rsp_found, bus.rsp_timeout, bus.rsp_vocab_addr};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic [3:0] pend);
    @(negedge clk);
    rst           = 1'b1;
    bus.req_valid = pend;
    bus.rsp_ready = 1'b0;
    eng_done      = 1'b0;
    #1;
    check("rst_eng_clr", eng_clr, 1);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_eng_cs", eng_cs, 0);
    @(negedge clk);
    rst           = 1'b0;
    bus.req_valid = '0;
    #1;
    check("post_rst_state", dbg_state, S_IDLE);
    check("post_rst_outs", {eng_clr, eng_cs, bus.req_ready, bus.rsp_valid}, 0);
    check("post_rst_cfg", {eng_input_start_addr, eng_vocab_start_addr, eng_vocab_end_addr}, 0);
    check("post_rst_rsp", rsp_now(), 0);
    model_ptr = 0;
  endtask

  // One full job: accept, clear, launch, engine done after `delay` WAIT cycles
  // (delay >= TIMEOUT means never), response held for rsp_wait cycles.
  task automatic do_job(input logic [3:0] valid, input logic [15:0] addrs, input int delay,
                        input logic fnd, input logic [3:0] av, input int rsp_wait,
                        output int gid);
    int         g, w, lat;
    logic [3:0] vs, ve, ia, onehot;
    logic [7:0] exp;
    bit         seen, ok;

    @(negedge clk);
    bus.rsp_ready      = 1'b0;
    bus.req_valid      = valid;
    bus.req_input_addr = addrs;
    vs                 = 4'($urandom_range(0, 15));
    ve                 = 4'($urandom_range(0, 15));
    vocab_start_addr   = vs;
    vocab_end_addr     = ve;
    #1;
    g      = model_grant(valid, model_ptr);
    gid    = g;
    ia     = addrs[g*4 +: 4];
    onehot = 4'b0001 << g;
    check("accept_req_ready", bus.req_ready, onehot);

    // CLEAR: scramble inputs to show the job config was latched at accept.
    @(negedge clk);
    vocab_start_addr   = 4'($urandom);
    vocab_end_addr     = 4'($urandom);
    bus.req_input_addr = 16'($urandom);
    #1;
    check("clear_eng_clr", eng_clr, 1);
    check("clear_eng_cs", eng_cs, 0);
    check("clear_req_ready", bus.req_ready, 0);

    // LAUNCH
    @(negedge clk);
    #1;
    check("launch_eng_cs", eng_cs, 1);
    check("launch_eng_clr", eng_clr, 0);
    check("launch_cfg", {eng_input_start_addr, eng_vocab_start_addr, eng_vocab_end_addr},
          {ia, vs, ve});

    // WAIT: count cycles from WAIT entry until rsp_valid shows up.
    seen = 1'b0;
    w    = 0;
    while (!seen && w <= TIMEOUT + 3) begin
      @(negedge clk);
      eng_done   = (w == delay);
      eng_found  = (w == delay) ? fnd : 1'($urandom_range(0, 1));
      eng_addr_v = (w == delay) ? av  : 4'($urandom);
      #1;
      if (bus.rsp_valid) seen = 1'b1;
      else begin
        check("wait_req_ready", bus.req_ready, 0);
        w++;
      end
    end
    eng_done = 1'b0;
    ok  = (delay <= TIMEOUT - 1);
    lat = ok ? delay + 1 : TIMEOUT;
    check("rsp_latency", w, lat);
    if (!seen) return;

    exp = {2'(g), ok ? fnd : 1'b0, ~ok, ok ? av : 4'h0};
    exp_q.push_back(exp);

    // RESP: fields stable while stalled, then handshake.
    for (int i = 0; i <= rsp_wait; i++) begin
      check("rsp_valid", bus.rsp_valid, 1);
      check("rsp_fields", rsp_now(), exp_q[0]);
      check("rsp_req_ready", bus.req_ready, 0);
      check("rsp_eng_cs", eng_cs, 0);
      if (i == rsp_wait) bus.rsp_ready = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    void'(exp_q.pop_front());
    model_ptr = (g + 1) % N_REQ;
  endtask

  // ---------------- global bound ----------------
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int gid;
    bus.req_valid      = '0;
    bus.req_input_addr = '0;
    bus.rsp_ready      = 1'b0;
    vocab_start_addr   = '0;
    vocab_end_addr     = '0;
    eng_done           = 1'b0;
    eng_found          = 1'b0;
    eng_addr_v         = '0;

    // Basic job from requester 2 with done in the first WAIT cycle.
    do_reset(4'b1111);
    do_job(4'b0100, 16'h0300, 0, 1'b1, 4'h7, 0, gid);
    check("basic_gid", gid, 2);

    // Fair rotation with all requesters active, then a sparse pattern.
    do_reset(4'b0000);
    for (int k = 0; k < 4; k++) begin
      do_job(4'b1111, 16'h4321, 1, 1'b1, 4'(k + 1), 0, gid);
      check("rr_order", gid, k);
    end
    do_job(4'b1010, 16'hA5C3, 1, 1'b0, 4'h2, 0, gid);
    check("sparse_first", gid, 1);
    do_job(4'b1010, 16'h5A3C, 1, 1'b1, 4'hE, 0, gid);
    check("sparse_second", gid, 3);

    // Watchdog expiry, then done landing exactly in the expiry cycle.
    do_job(4'b0001, 16'h000B, 1000, 1'b1, 4'hF, 0, gid);
    do_job(4'b0010, 16'h00D0, TIMEOUT - 1, 1'b0, 4'h9, 0, gid);

    // Long consumer stall with others pending, then immediate next grant.
    do_job(4'b1111, 16'h1234, 2, 1'b1, 4'h6, 10, gid);
    do_job(4'b1111, 16'h8765, 0, 1'b0, 4'h1, 0, gid);

    // Reset in the middle of requester 2's job.
    do_job(4'b0100, 16'h0500, 0, 1'b1, 4'h3, 0, gid);   // leaves pointer at 3
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0100;
    #1;
    check("mid_accept", bus.req_ready, 4'b0100);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid_launch", eng_cs, 1);
    @(negedge clk);
    #1;
    check("mid_wait_rsp", bus.rsp_valid, 0);
    do_reset(4'b1100);
    do_job(4'b1100, 16'h9A00, 0, 1'b1, 4'hC, 0, gid);
    check("post_reset_grant", gid, 2);

    // Randomized jobs.
    for (int n = 0; n < 40; n++) begin
      do_job(4'($urandom_range(1, 15)), 16'($urandom),
             $urandom_range(0, TIMEOUT + 2), 1'($urandom_range(0, 1)),
             4'($urandom), $urandom_range(0, 3), gid);
    end

    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = '0;
    #1;
    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
